// File: rtl/gbuff_skew_feeder_pkg.sv
// Shared constants and FSM encoding for the global-buffer skew feeder.
package gbuff_skew_feeder_pkg;

  localparam int GB_WORD_W = 32;
  localparam int GB_LANES  = 4;
  localparam int GB_DATA_W = 8;
  localparam int GB_ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/gbuff_skew_feeder_skew_delay_line.sv
// Fixed-depth shift register carrying one lane's operand and its valid bit.
module skew_delay_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  logic [DEPTH-1:0][DATA_W:0] stages;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages[0] <= {in_valid, in_data};
      for (int j = 1; j < DEPTH; j++) begin
        stages[j] <= stages[j-1];
      end
    end
  end

  assign out_data  = stages[DEPTH-1][DATA_W-1:0];
  assign out_valid = stages[DEPTH-1][DATA_W];

endmodule

// File: rtl/gbuff_skew_feeder.sv
// Streams len words from the global buffer and emits their bytes diagonally
// skewed (lane i delayed i cycles) for the systolic array edge.
module gbuff_skew_feeder
  import gbuff_skew_feeder_pkg::*;
#(
  parameter int LANES  = GB_WORD_W / GB_DATA_W,
  parameter int DATA_W = GB_DATA_W,
  parameter int ADDR_W = GB_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W:0]         len,
  output logic                    busy,
  output logic                    done,
  output logic                    gb_rd,
  output logic [ADDR_W-1:0]       gb_index,
  input  logic [LANES*DATA_W-1:0] gb_rdata,
  output logic [LANES*DATA_W-1:0] lane_data,
  output logic [LANES-1:0]        lane_valid
);

  localparam int DCNT_W = $clog2(LANES + 2);

  feeder_state_t state, next_state;

  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   rd_cnt;
  logic [ADDR_W-1:0] idx;
  logic [DCNT_W-1:0] drain_cnt;
  logic              rd_tag;
  logic              last_read;
  logic              drain_last;

  assign last_read  = ((rd_cnt + (ADDR_W+1)'(1)) == len_q);
  assign drain_last = (drain_cnt == DCNT_W'(LANES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = (len == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (last_read) begin
          next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_last) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // The index stops advancing on the last read so it holds through DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      rd_cnt    <= '0;
      idx       <= '0;
      drain_cnt <= '0;
      rd_tag    <= 1'b0;
    end else begin
      rd_tag <= (state == ST_READ);
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q     <= len;
            rd_cnt    <= '0;
            idx       <= base_addr;
            drain_cnt <= '0;
          end
        end
        ST_READ: begin
          rd_cnt    <= rd_cnt + (ADDR_W+1)'(1);
          drain_cnt <= '0;
          if (!last_read) begin
            idx <= idx + ADDR_W'(1);
          end
        end
        ST_DRAIN: drain_cnt <= drain_cnt + DCNT_W'(1);
        default: ;
      endcase
    end
  end

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign gb_rd    = (state == ST_READ);
  assign gb_index = idx;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_W-1:0] line_data;

    skew_delay_line #(
      .DEPTH (i + 1),
      .DATA_W(DATA_W)
    ) u_line (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (gb_rdata[DATA_W*i +: DATA_W]),
      .in_valid (rd_tag),
      .out_data (line_data),
      .out_valid(lane_valid[i])
    );

    assign lane_data[DATA_W*i +: DATA_W] = lane_valid[i] ? line_data : '0;
  end

endmodule

// File: tb/tb_gbuff_skew_feeder.sv
// Directed bench for gbuff_skew_feeder with a registered-read buffer model
// and per-cycle expectations derived from the documented stream timing.
module tb_gbuff_skew_feeder;
  import gbuff_skew_feeder_pkg::*;

  localparam int LANES  = GB_LANES;
  localparam int DATA_W = GB_DATA_W;
  localparam int ADDR_W = GB_ADDR_W;
  localparam int WORD_W = GB_WORD_W;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              gb_rd;
  logic [ADDR_W-1:0] gb_index;
  logic [WORD_W-1:0] gb_rdata;
  logic [WORD_W-1:0] lane_data;
  logic [LANES-1:0]  lane_valid;

  logic [WORD_W-1:0] mem [0:DEPTH-1];

  int checks   = 0;
  int failures = 0;

  gbuff_skew_feeder #(
    .LANES (LANES),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .gb_rd     (gb_rd),
    .gb_index  (gb_index),
    .gb_rdata  (gb_rdata),
    .lane_data (lane_data),
    .lane_valid(lane_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer presents data_out one cycle after the index.
  always @(posedge clk) gb_rdata <= mem[gb_index];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l);
    start     = s;
    base_addr = b;
    len       = l;
  endtask

  // Caller is in cycle 0; returns in cycle len+LANES+3 (or 2 for len=0).
  task automatic runStream(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l,
                           input bit spurious, input string name);
    int                last;
    int                k;
    logic [WORD_W-1:0] w;
    logic [WORD_W-1:0] exp_data;
    logic [LANES-1:0]  exp_valid;
    logic [ADDR_W-1:0] exp_idx;

    last = (l == 0) ? 1 : int'(l) + LANES + 2;
    checkOutput($sformatf("%s c0 busy", name), 64'(busy), 64'(0));
    checkOutput($sformatf("%s c0 lane_valid", name), 64'(lane_valid), 64'(0));
    applyStimulus(1'b1, b, l);
    tick();
    applyStimulus(1'b0, ADDR_W'($urandom), (ADDR_W+1)'($urandom));
    for (int c = 1; c <= last; c++) begin
      if (spurious && c == 2) applyStimulus(1'b1, b + ADDR_W'(40), (ADDR_W+1)'(5));
      if (spurious && c == 3) applyStimulus(1'b0, b, l);
      checkOutput($sformatf("%s c%0d busy", name, c), 64'(busy), 64'(1));
      checkOutput($sformatf("%s c%0d done", name, c), 64'(done), 64'(c == last));
      checkOutput($sformatf("%s c%0d gb_rd", name, c), 64'(gb_rd), 64'(c <= int'(l)));
      if (c <= int'(l)) begin
        exp_idx = ADDR_W'(int'(b) + c - 1);
        checkOutput($sformatf("%s c%0d gb_index", name, c), 64'(gb_index), 64'(exp_idx));
      end else if (l != 0 && c < last) begin
        exp_idx = ADDR_W'(int'(b) + int'(l) - 1);
        checkOutput($sformatf("%s c%0d gb_index hold", name, c), 64'(gb_index), 64'(exp_idx));
      end
      exp_valid = '0;
      exp_data  = '0;
      for (int i = 0; i < LANES; i++) begin
        k = c - 3 - i;
        if (k >= 0 && k < int'(l)) begin
          exp_valid[i] = 1'b1;
          w = mem[(int'(b) + k) % DEPTH];
          exp_data[DATA_W*i +: DATA_W] = w[DATA_W*i +: DATA_W];
        end
      end
      checkOutput($sformatf("%s c%0d lane_valid", name, c), 64'(lane_valid), 64'(exp_valid));
      checkOutput($sformatf("%s c%0d lane_data", name, c), 64'(lane_data), 64'(exp_data));
      tick();
    end
    checkOutput($sformatf("%s end busy", name), 64'(busy), 64'(0));
    checkOutput($sformatf("%s end done", name), 64'(done), 64'(0));
  endtask

  initial begin
    $display("[TB] gbuff_skew_feeder bench starting");
    for (int a = 0; a < DEPTH; a++) begin
      mem[a] = {8'(a + 48), 8'(a + 32), 8'(a + 16), 8'(a)};
    end
    mem[10] = 32'h0403_0201;
    mem[11] = 32'h0807_0605;
    mem[12] = 32'h0C0B_0A09;

    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0);
    tick();
    tick();
    checkOutput("reset busy", 64'(busy), 64'(0));
    checkOutput("reset done", 64'(done), 64'(0));
    checkOutput("reset gb_rd", 64'(gb_rd), 64'(0));
    checkOutput("reset gb_index", 64'(gb_index), 64'(0));
    checkOutput("reset lane_data", 64'(lane_data), 64'(0));
    checkOutput("reset lane_valid", 64'(lane_valid), 64'(0));
    rst_n = 1'b1;
    tick();

    $display("[TB] basic three-word stream");
    runStream(ADDR_W'(10), (ADDR_W+1)'(3), 1'b0, "basic");

    $display("[TB] address wrap");
    runStream(ADDR_W'(254), (ADDR_W+1)'(4), 1'b0, "wrap");

    $display("[TB] zero length");
    runStream(ADDR_W'(77), (ADDR_W+1)'(0), 1'b0, "len0");

    $display("[TB] start during READ, then back-to-back start");
    runStream(ADDR_W'(20), (ADDR_W+1)'(5), 1'b1, "spurious");
    runStream(ADDR_W'(30), (ADDR_W+1)'(2), 1'b0, "b2b");

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, ADDR_W'(100), (ADDR_W+1)'(8));
    tick();
    applyStimulus(1'b0, '0, '0);
    tick();
    tick();
    tick();
    checkOutput("midrst pre lane0 valid", 64'(lane_valid[0]), 64'(1));
    checkOutput("midrst pre busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("midrst busy", 64'(busy), 64'(0));
    checkOutput("midrst done", 64'(done), 64'(0));
    checkOutput("midrst gb_rd", 64'(gb_rd), 64'(0));
    checkOutput("midrst gb_index", 64'(gb_index), 64'(0));
    checkOutput("midrst lane_data", 64'(lane_data), 64'(0));
    checkOutput("midrst lane_valid", 64'(lane_valid), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      checkOutput($sformatf("postrst c%0d done", c), 64'(done), 64'(0));
      checkOutput($sformatf("postrst c%0d busy", c), 64'(busy), 64'(0));
    end
    runStream(ADDR_W'(5), (ADDR_W+1)'(6), 1'b0, "afterrst");

    $display("[TB] full-depth stream");
    runStream(ADDR_W'(0), (ADDR_W+1)'(256), 1'b0, "full");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
